// File: rtl/pc_escalonador_if.sv
// Fetch-stage bus between the datapath and the program-counter scheduler.
interface pc_escalonador_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned N_PROG = 5
);
    localparam int unsigned PW = $clog2(N_PROG + 1);

    logic              stop;
    logic              lpc;
    logic              endProgram;
    logic [2:0]        desvio;
    logic [ADDR_W-1:0] novoEnd;
    logic [ADDR_W-1:0] novoEndR;
    logic              zero;
    logic              negativo;
    logic [ADDR_W-1:0] endereco;
    logic [ADDR_W-1:0] enderecoSpc;
    logic [PW-1:0]     programa;
    logic              troca;
    logic              todosFim;

    // Datapath side: drives control/flags, observes fetch address and context.
    modport master (
        output stop, lpc, endProgram, desvio, novoEnd, novoEndR, zero, negativo,
        input  endereco, enderecoSpc, programa, troca, todosFim
    );

    // Scheduler side.
    modport slave (
        input  stop, lpc, endProgram, desvio, novoEnd, novoEndR, zero, negativo,
        output endereco, enderecoSpc, programa, troca, todosFim
    );
endinterface

// File: rtl/pc_escalonador.sv
// Program counter with round-robin time-slice scheduling of N user programs
// under an OS context (program 0); saves/restores per-program PCs.
module pc_escalonador #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned N_PROG    = 5,
    parameter int unsigned QUANTUM   = 5,
    parameter int unsigned PROG_BASE = 1000,
    parameter int unsigned SO_BASE   = 0
) (
    input  logic             clock,
    input  logic             reset,
    pc_escalonador_if.slave  bus
);
    localparam int unsigned PW  = $clog2(N_PROG + 1);
    localparam int unsigned PW1 = PW + 1;
    localparam int unsigned IW  = $clog2(QUANTUM + 1);

    logic [ADDR_W-1:0]             endereco_q, endereco_d;
    logic [ADDR_W-1:0]             spc_q, spc_d;
    logic [PW-1:0]                 programa_q, programa_d;
    logic                          troca_q, troca_d;
    logic                          todos_fim_q, todos_fim_d;
    logic [IW-1:0]                 inst_q, inst_d;
    logic [PW-1:0]                 prog_ant_q, prog_ant_d;
    logic [N_PROG:1][ADDR_W-1:0]   ctx_q, ctx_d;
    logic [N_PROG:1]               fim_q, fim_d;

    logic [ADDR_W-1:0]             off_c;
    logic [ADDR_W-1:0]             branch_pc_c;
    logic [ADDR_W-1:0]             pc_inc_c;
    logic [ADDR_W-1:0]             rel_tgt_c;
    logic                          found_c;
    logic [PW-1:0]                 nxt_c;
    logic [PW:0]                   cand_c;
    logic                          switch_c;

    // Window offset of the running context and next-PC per branch type.
    always_comb begin
        off_c       = ADDR_W'(programa_q) * ADDR_W'(PROG_BASE);
        pc_inc_c    = endereco_q + ADDR_W'(1);
        rel_tgt_c   = bus.novoEnd + off_c;
        branch_pc_c = pc_inc_c;
        unique case (bus.desvio)
            3'b000:  branch_pc_c = pc_inc_c;
            3'b001:  branch_pc_c = rel_tgt_c;
            3'b010:  branch_pc_c = bus.zero ? rel_tgt_c : pc_inc_c;
            3'b100:  branch_pc_c = bus.zero ? pc_inc_c : rel_tgt_c;
            3'b101:  branch_pc_c = bus.negativo ? rel_tgt_c : pc_inc_c;
            3'b110:  branch_pc_c = (bus.negativo | bus.zero) ? rel_tgt_c : pc_inc_c;
            3'b011:  branch_pc_c = bus.novoEndR;
            default: branch_pc_c = endereco_q;
        endcase
    end

    // Round-robin search for the next unfinished program after the last one run.
    always_comb begin
        found_c = 1'b0;
        nxt_c   = '0;
        cand_c  = '0;
        for (int k = 1; k <= int'(N_PROG); k++) begin
            cand_c = PW1'(prog_ant_q) + PW1'(k);
            if (cand_c > PW1'(N_PROG)) begin
                cand_c = cand_c - PW1'(N_PROG);
            end
            if (!found_c && !fim_q[PW'(cand_c)]) begin
                found_c = 1'b1;
                nxt_c   = PW'(cand_c);
            end
        end
    end

    // Slice ends on quantum expiry or program halt, but only on a sequential instruction.
    always_comb begin
        switch_c = ((inst_q >= IW'(QUANTUM)) || bus.endProgram) && (bus.desvio == 3'b000);
    end

    // Next-state: OS dispatch, user slice advance, or context switch back to OS.
    always_comb begin
        endereco_d = endereco_q;
        spc_d      = spc_q;
        programa_d = programa_q;
        troca_d    = 1'b0;
        inst_d     = inst_q;
        prog_ant_d = prog_ant_q;
        ctx_d      = ctx_q;
        fim_d      = fim_q;
        if (!bus.stop) begin
            if (programa_q == '0) begin
                if (bus.lpc && found_c) begin
                    endereco_d = ADDR_W'(nxt_c) * ADDR_W'(PROG_BASE) + ctx_q[nxt_c];
                    programa_d = nxt_c;
                    inst_d     = IW'(1);
                end else begin
                    endereco_d = branch_pc_c;
                end
            end else if (switch_c) begin
                ctx_d[programa_q] = pc_inc_c - off_c;
                spc_d             = pc_inc_c;
                endereco_d        = ADDR_W'(SO_BASE);
                prog_ant_d        = programa_q;
                programa_d        = '0;
                inst_d            = '0;
                troca_d           = 1'b1;
                if (bus.endProgram) begin
                    fim_d[programa_q] = 1'b1;
                end
            end else begin
                endereco_d = branch_pc_c;
                if (inst_q < IW'(QUANTUM)) begin
                    inst_d = inst_q + IW'(1);
                end
            end
        end
        todos_fim_d = &fim_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            endereco_q  <= ADDR_W'(SO_BASE);
            spc_q       <= '0;
            programa_q  <= '0;
            troca_q     <= 1'b0;
            todos_fim_q <= 1'b0;
            inst_q      <= '0;
            prog_ant_q  <= PW'(N_PROG);
            ctx_q       <= '0;
            fim_q       <= '0;
        end else begin
            endereco_q  <= endereco_d;
            spc_q       <= spc_d;
            programa_q  <= programa_d;
            troca_q     <= troca_d;
            todos_fim_q <= todos_fim_d;
            inst_q      <= inst_d;
            prog_ant_q  <= prog_ant_d;
            ctx_q       <= ctx_d;
            fim_q       <= fim_d;
        end
    end

    assign bus.endereco    = endereco_q;
    assign bus.enderecoSpc = spc_q;
    assign bus.programa    = programa_q;
    assign bus.troca       = troca_q;
    assign bus.todosFim    = todos_fim_q;
endmodule

// File: tb/tb_pc_escalonador.sv
// Directed bench for pc_escalonador with N_PROG=3, QUANTUM=3, PROG_BASE=1000.
module tb_pc_escalonador;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned N_PROG = 3;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    pc_escalonador_if #(.ADDR_W(ADDR_W), .N_PROG(N_PROG)) bus ();

    pc_escalonador #(
        .ADDR_W   (ADDR_W),
        .N_PROG   (N_PROG),
        .QUANTUM  (3),
        .PROG_BASE(1000),
        .SO_BASE  (0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value against its expected value.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic lpc, input logic endp, input logic [2:0] desvio,
                         input logic [31:0] novo_end);
        bus.lpc        = lpc;
        bus.endProgram = endp;
        bus.desvio     = desvio;
        bus.novoEnd    = novo_end;
    endtask

    // Expect fetch address, context and troca after one edge.
    task automatic step_chk(input string tag, input logic [31:0] adr, input logic [31:0] prg,
                            input logic trc);
        tick();
        check_eq({tag, ".endereco"}, bus.endereco, adr);
        check_eq({tag, ".programa"}, 32'(bus.programa), prg);
        check_eq({tag, ".troca"}, 32'(bus.troca), 32'(trc));
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus.stop     = 1'b0;
        bus.lpc      = 1'b0;
        bus.endProgram = 1'b0;
        bus.desvio   = 3'b000;
        bus.novoEnd  = '0;
        bus.novoEndR = '0;
        bus.zero     = 1'b0;
        bus.negativo = 1'b0;
        tick();
        tick();
        check_eq("rst.endereco", bus.endereco, 0);
        check_eq("rst.programa", 32'(bus.programa), 0);
        check_eq("rst.spc", bus.enderecoSpc, 0);
        check_eq("rst.troca", 32'(bus.troca), 0);
        check_eq("rst.todosFim", 32'(bus.todosFim), 0);
        reset = 1'b0;

        // Program 1 full slice.
        drive(1, 0, 3'b000, 0);
        step_chk("p1a", 1000, 1, 0);
        drive(0, 0, 3'b000, 0);
        step_chk("p1b", 1001, 1, 0);
        step_chk("p1c", 1002, 1, 0);
        step_chk("p1sw", 0, 0, 1);
        check_eq("p1sw.spc", bus.enderecoSpc, 1003);
        step_chk("so1", 1, 0, 0);

        // Programs 2 and 3 full slices, then program 1 resumes.
        drive(1, 0, 3'b000, 0);
        step_chk("p2a", 2000, 2, 0);
        drive(0, 0, 3'b000, 0);
        step_chk("p2b", 2001, 2, 0);
        step_chk("p2c", 2002, 2, 0);
        step_chk("p2sw", 0, 0, 1);
        check_eq("p2sw.spc", bus.enderecoSpc, 2003);
        drive(1, 0, 3'b000, 0);
        step_chk("p3a", 3000, 3, 0);
        drive(0, 0, 3'b000, 0);
        step_chk("p3b", 3001, 3, 0);
        step_chk("p3c", 3002, 3, 0);
        step_chk("p3sw", 0, 0, 1);
        drive(1, 0, 3'b000, 0);
        step_chk("p1res", 1003, 1, 0);

        // Branch at quantum expiry defers the switch.
        drive(0, 0, 3'b000, 0);
        step_chk("p1d", 1004, 1, 0);
        step_chk("p1e", 1005, 1, 0);
        drive(0, 0, 3'b001, 40);
        step_chk("p1br", 1040, 1, 0);
        drive(0, 0, 3'b000, 0);
        step_chk("p1dsw", 0, 0, 1);
        check_eq("p1dsw.spc", bus.enderecoSpc, 1041);

        // Program 2 halts early.
        drive(1, 0, 3'b000, 0);
        step_chk("p2res", 2003, 2, 0);
        drive(0, 0, 3'b000, 0);
        step_chk("p2f", 2004, 2, 0);
        drive(0, 1, 3'b000, 0);
        step_chk("p2end", 0, 0, 1);
        check_eq("p2end.spc", bus.enderecoSpc, 2005);
        check_eq("p2end.todosFim", 32'(bus.todosFim), 0);

        // Program 3 slice.
        drive(1, 0, 3'b000, 0);
        step_chk("p3res", 3003, 3, 0);
        drive(0, 0, 3'b000, 0);
        step_chk("p3d", 3004, 3, 0);
        step_chk("p3e", 3005, 3, 0);
        step_chk("p3sw2", 0, 0, 1);

        // Program 1 resumes; stop freezes it mid-slice.
        drive(1, 0, 3'b000, 0);
        step_chk("p1res2", 1041, 1, 0);
        drive(0, 0, 3'b000, 0);
        bus.stop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step_chk("stop", 1041, 1, 0);
        end
        bus.stop = 1'b0;
        step_chk("p1g", 1042, 1, 0);
        step_chk("p1h", 1043, 1, 0);
        drive(0, 1, 3'b000, 0);
        step_chk("p1end", 0, 0, 1);
        check_eq("p1end.spc", bus.enderecoSpc, 1044);

        // Only program 3 remains; program 2 is skipped.
        drive(1, 0, 3'b000, 0);
        step_chk("p3skip2", 3006, 3, 0);
        drive(0, 1, 3'b000, 0);
        step_chk("p3end", 0, 0, 1);
        check_eq("p3end.spc", bus.enderecoSpc, 3007);
        check_eq("all.todosFim", 32'(bus.todosFim), 1);

        // All finished: lpc ignored, OS keeps stepping.
        drive(1, 0, 3'b000, 0);
        step_chk("idle1", 1, 0, 0);
        step_chk("idle2", 2, 0, 0);
        check_eq("idle.todosFim", 32'(bus.todosFim), 1);

        // Branch types in OS mode (offset 0).
        bus.novoEndR = 500;
        drive(0, 0, 3'b011, 0);
        step_chk("br011", 500, 0, 0);
        drive(0, 0, 3'b111, 0);
        step_chk("br111", 500, 0, 0);
        bus.zero = 1'b1;
        drive(0, 0, 3'b010, 20);
        step_chk("br010t", 20, 0, 0);
        drive(0, 0, 3'b100, 99);
        step_chk("br100z", 21, 0, 0);
        bus.zero = 1'b0;
        drive(0, 0, 3'b101, 99);
        step_chk("br101n", 22, 0, 0);
        bus.negativo = 1'b1;
        drive(0, 0, 3'b110, 7);
        step_chk("br110t", 7, 0, 0);
        bus.negativo = 1'b0;
        drive(0, 0, 3'b100, 60);
        step_chk("br100t", 60, 0, 0);

        // Reset wins over stop and clears all scheduling state.
        drive(0, 0, 3'b000, 0);
        bus.stop = 1'b1;
        reset    = 1'b1;
        step_chk("rststop", 0, 0, 0);
        check_eq("rststop.todosFim", 32'(bus.todosFim), 0);
        check_eq("rststop.spc", bus.enderecoSpc, 0);
        reset    = 1'b0;
        bus.stop = 1'b0;
        drive(1, 0, 3'b000, 0);
        step_chk("post_rst", 1000, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
